// File: rtl/uart_tx.sv
// Purpose : 8N1/8N2 UART transmitter, LSB first, CLKS_PER_BIT clocks per bit.
// Latency : line falls on the accepting edge; done pulses (9+STOP_BITS)*CLKS_PER_BIT cycles later.
// Backpres: tx_busy high while a frame is in flight; tx_start is ignored (not queued) meanwhile.
module uart_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done_out
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic              r_stop_cnt;
    logic [7:0]        r_shift;
    logic              r_tx_out;
    logic              r_busy;
    logic              r_done;
    logic              w_baud_wrap;

    // Last clock of the current bit period.
    assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);

    assign tx_out      = r_tx_out;
    assign tx_busy     = r_busy;
    assign tx_done_out = r_done;

    // Frame sequencer: every output is registered, the line is driven straight from r_tx_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx_out <= 1'b1;
                    if (tx_start) begin
                        // Byte is latched here so later data_in changes cannot disturb the frame.
                        r_shift    <= data_in;
                        r_state    <= S_START;
                        r_tx_out   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_baud_cnt <= '0;
                    end
                end

                S_START: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_DATA;
                        r_tx_out   <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_bit_cnt  <= '0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_state    <= S_STOP;
                            r_tx_out   <= 1'b1;
                            r_stop_cnt <= 1'b0;
                        end else begin
                            // Shift register always presents the next data bit at bit 0.
                            r_tx_out  <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (r_stop_cnt == STOP_LAST) begin
                            // Back in IDLE this cycle, so a held tx_start is taken on the next edge.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_tx_out <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) at 4 clocks per bit,
// each frame compared cycle by cycle against an ideal waveform built from the byte.
module tb_uart_tx;

    localparam int CPB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      tx_start;
    logic [1:0][7:0] data_in;
    logic [1:0]      tx_out;
    logic [1:0]      tx_busy;
    logic [1:0]      tx_done;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_start    (tx_start[0]),
        .data_in     (data_in[0]),
        .tx_out      (tx_out[0]),
        .tx_busy     (tx_busy[0]),
        .tx_done_out (tx_done[0])
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_start    (tx_start[1]),
        .data_in     (data_in[1]),
        .tx_out      (tx_out[1]),
        .tx_busy     (tx_busy[1]),
        .tx_done_out (tx_done[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ideal line level i cycles after acceptance: start bit, 8 data bits LSB first,
    // then stop bits; each bit lasts CPB cycles.
    function automatic logic model_line(input logic [7:0] b, input int i);
        int bit_idx;
        bit_idx = i / CPB;
        if (bit_idx == 0) return 1'b0;
        if (bit_idx <= 8) return b[bit_idx-1];
        return 1'b1;
    endfunction

    // Drive a request on instance s; it is accepted on the following rising edge.
    task automatic request(input int s, input logic [7:0] b);
        @(negedge clk);
        tx_start[s] = 1'b1;
        data_in[s]  = b;
    endtask

    // Check one frame from the accepting edge up to and including the done cycle.
    // hold keeps tx_start high (next byte = next_dat); poke_at >= 0 fires a request while busy.
    task automatic frame(input int s, input logic [7:0] b, input bit hold,
                         input logic [7:0] next_dat, input int poke_at);
        int len;
        len = (10 + s) * CPB;
        @(negedge clk);
        if (hold) begin
            data_in[s] = next_dat;
        end else begin
            tx_start[s] = 1'b0;
            data_in[s]  = 8'($urandom);
        end
        for (int i = 0; i <= len; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("line%0d_c%0d", s, i), 32'(tx_out[s]), 32'(model_line(b, i)));
            check($sformatf("busy%0d_c%0d", s, i), 32'(tx_busy[s]), 32'(i < len));
            check($sformatf("done%0d_c%0d", s, i), 32'(tx_done[s]), 32'(i == len));
            if (!hold && i == poke_at) begin
                tx_start[s] = 1'b1;
                data_in[s]  = 8'($urandom);
            end else if (!hold && i == poke_at + 1) begin
                tx_start[s] = 1'b0;
            end
        end
    endtask

    task automatic idle_check(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle_line%0d", s), 32'(tx_out[s]), 32'd1);
            check($sformatf("idle_busy%0d", s), 32'(tx_busy[s]), 32'd0);
            check($sformatf("idle_done%0d", s), 32'(tx_done[s]), 32'd0);
        end
    endtask

    task automatic reset_state_check(input string tag);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("%s_line%0d", tag, s), 32'(tx_out[s]), 32'd1);
            check($sformatf("%s_busy%0d", tag, s), 32'(tx_busy[s]), 32'd0);
            check($sformatf("%s_done%0d", tag, s), 32'(tx_done[s]), 32'd0);
        end
    endtask

    initial begin
        tx_start = 2'b11;
        data_in  = '0;
        rst_n    = 1'b1;

        // Reset acts without a clock edge, whatever the inputs.
        #2 rst_n = 1'b0;
        #1 reset_state_check("rst_async");
        repeat (2) @(negedge clk);
        reset_state_check("rst_held");

        // Request pending while reset releases: first edge with rst_n high accepts it.
        tx_start = 2'b00;
        @(negedge clk);
        tx_start[0] = 1'b1;
        data_in[0]  = 8'h11;
        rst_n       = 1'b1;
        frame(0, 8'h11, 1'b0, 8'h00, -1);
        idle_check(0, 2);

        // Single byte, one stop bit.
        request(0, 8'hA5);
        frame(0, 8'hA5, 1'b0, 8'h00, -1);
        idle_check(0, 2);

        // Request during data bit 2 is dropped.
        request(0, 8'h3C);
        frame(0, 8'h3C, 1'b0, 8'h00, 3 * CPB + 1);
        idle_check(0, 3);

        // Back-to-back with tx_start held: one idle-high cycle (the done cycle) between frames.
        request(0, 8'h00);
        frame(0, 8'h00, 1'b1, 8'hFF, -1);
        frame(0, 8'hFF, 1'b0, 8'h00, -1);
        idle_check(0, 2);

        // Two stop bits.
        request(1, 8'h80);
        frame(1, 8'h80, 1'b0, 8'h00, -1);
        idle_check(1, 2);

        // Reset during data bit 3 abandons the frame with no done pulse.
        request(0, 8'h55);
        @(negedge clk);
        tx_start[0] = 1'b0;
        for (int i = 0; i < 4 * CPB + 2; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("rst_frame_c%0d", i), 32'(tx_out[0]), 32'(model_line(8'h55, i)));
        end
        #1 rst_n = 1'b0;
        #1 reset_state_check("rst_mid");
        repeat (2) begin
            @(negedge clk);
            reset_state_check("rst_mid_held");
        end
        rst_n = 1'b1;
        idle_check(0, 2);
        request(0, 8'h0F);
        frame(0, 8'h0F, 1'b0, 8'h00, -1);
        idle_check(0, 1);

        // Randomised frames on both instances, with random busy pokes and held starts.
        for (int k = 0; k < 14; k++) begin
            int          s;
            logic [7:0]  b;
            logic [7:0]  b2;
            int          len;
            s   = int'($urandom_range(0, 1));
            b   = 8'($urandom);
            b2  = 8'($urandom);
            len = (10 + s) * CPB;
            request(s, b);
            if ($urandom_range(0, 2) == 0) begin
                frame(s, b, 1'b1, b2, -1);
                frame(s, b2, 1'b0, 8'h00, -1);
            end else begin
                frame(s, b, 1'b0, 8'h00,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1);
            end
            idle_check(s, int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
